// File: rtl/video_timing_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : video_timing_gen_pkg                                         |
// | Description : Shared raster timing types and the 720p default timing.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package video_timing_gen_pkg;

  // Raster counters are 11 bits wide, so the largest usable total is 2047.
  localparam int CNT_W   = 11;
  localparam int CNT_MAX = 2047;

  typedef logic [CNT_W-1:0] count_t;

  typedef struct packed {
    count_t h_active;
    count_t h_fp;
    count_t h_sync;
    count_t h_bp;
    count_t v_active;
    count_t v_fp;
    count_t v_sync;
    count_t v_bp;
  } video_timing_t;

  localparam video_timing_t TIMING_720P = '{
    h_active: 11'd1280, h_fp: 11'd110, h_sync: 11'd40, h_bp: 11'd220,
    v_active: 11'd720,  v_fp: 11'd5,   v_sync: 11'd5,  v_bp: 11'd20
  };

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_sync_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_delay_line                                              |
// | Description : Reset-cleared shift register for the {hsync,vsync,de} bundle.|
// |               Each bit resets to its own inactive level (RESET_VAL).       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             pixel_clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift the bundle one stage per pixel clock; reset forces every stage inactive.
  always_ff @(posedge pixel_clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : video_timing_gen                                             |
// | Description : Raster timing source. Produces raw hsync/vsync for the       |
// |               renderer, then realigns the rendered pixel stream with       |
// |               delayed sync/data-enable for the display PHY.                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = int'(TIMING_720P.h_active),
  parameter int H_FP     = int'(TIMING_720P.h_fp),
  parameter int H_SYNC   = int'(TIMING_720P.h_sync),
  parameter int H_BP     = int'(TIMING_720P.h_bp),
  parameter int V_ACTIVE = int'(TIMING_720P.v_active),
  parameter int V_FP     = int'(TIMING_720P.v_fp),
  parameter int V_SYNC   = int'(TIMING_720P.v_sync),
  parameter int V_BP     = int'(TIMING_720P.v_bp),
  parameter bit SYNC_POL = 1'b1,
  parameter int LATENCY  = 4
) (
  input  logic        pixel_clk_i,
  input  logic        reset_i,
  output logic        hsync_o,
  output logic        vsync_o,
  input  logic [31:0] pixel_data_i,
  output logic        disp_hsync_o,
  output logic        disp_vsync_o,
  output logic        disp_de_o,
  output logic [23:0] disp_rgb_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_range_err
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
  end
  if (LATENCY < 1) begin : g_latency_err
    $error("video_timing_gen: LATENCY must be at least 1");
  end

  localparam count_t H_LAST    = count_t'(H_TOTAL - 1);
  localparam count_t V_LAST    = count_t'(V_TOTAL - 1);
  localparam count_t H_ACT_END = count_t'(H_ACTIVE);
  localparam count_t V_ACT_END = count_t'(V_ACTIVE);
  localparam count_t HS_START  = count_t'(H_ACTIVE + H_FP);
  localparam count_t HS_END    = count_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam count_t VS_START  = count_t'(V_ACTIVE + V_FP);
  localparam count_t VS_END    = count_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic   SYNC_ACT  = SYNC_POL;
  localparam logic   SYNC_IDLE = ~SYNC_POL;

  count_t h_cnt_q, h_cnt_d;
  count_t v_cnt_q, v_cnt_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   de_raw_q, de_raw_d;
  logic   frame_start_q, frame_start_d;
  logic   disp_hsync_q, disp_vsync_q, disp_de_q;
  logic [23:0] disp_rgb_q;
  logic [2:0]  dly_w;
  logic        unused_alpha;

  // Alpha byte is carried by the renderer but never displayed.
  assign unused_alpha = ^pixel_data_i[7:0];

  // Raster position: h wraps every line, v advances only on the h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + count_t'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + count_t'(1);
    end
  end

  // Decode the current position into sync/de/frame-start levels.
  always_comb begin
    hsync_d       = (h_cnt_q >= HS_START && h_cnt_q < HS_END) ? SYNC_ACT : SYNC_IDLE;
    vsync_d       = (v_cnt_q >= VS_START && v_cnt_q < VS_END) ? SYNC_ACT : SYNC_IDLE;
    de_raw_d      = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Counters and registered raw decode; reset restarts a fresh frame at (0,0).
  always_ff @(posedge pixel_clk_i or posedge reset_i) begin
    if (reset_i) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      de_raw_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_raw_q      <= de_raw_d;
      frame_start_q <= frame_start_d;
    end
  end

  sync_delay_line #(
    .WIDTH    (3),
    .DEPTH    (LATENCY),
    .RESET_VAL({SYNC_IDLE, SYNC_IDLE, 1'b0})
  ) u_sync_delay (
    .pixel_clk_i(pixel_clk_i),
    .reset_i    (reset_i),
    .data_i     ({hsync_q, vsync_q, de_raw_q}),
    .data_o     (dly_w)
  );

  // Display side: one register after the delay line, capturing pixel data gated by delayed de.
  always_ff @(posedge pixel_clk_i or posedge reset_i) begin
    if (reset_i) begin
      disp_hsync_q <= SYNC_IDLE;
      disp_vsync_q <= SYNC_IDLE;
      disp_de_q    <= 1'b0;
      disp_rgb_q   <= '0;
    end else begin
      disp_hsync_q <= dly_w[2];
      disp_vsync_q <= dly_w[1];
      disp_de_q    <= dly_w[0];
      disp_rgb_q   <= dly_w[0] ? pixel_data_i[31:8] : 24'h0;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign frame_start_o = frame_start_q;
  assign disp_hsync_o  = disp_hsync_q;
  assign disp_vsync_o  = disp_vsync_q;
  assign disp_de_o     = disp_de_q;
  assign disp_rgb_o    = disp_rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_video_timing_gen                                          |
// | Description : Self-checking bench for video_timing_gen, small raster,      |
// |               both sync polarities, arithmetic reference model.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int LAT = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pd  = '0;

  logic hs_p, vs_p, dhs_p, dvs_p, de_p, fs_p;
  logic hs_n, vs_n, dhs_n, dvs_n, de_n, fs_n;
  logic [23:0] rgb_p, rgb_n;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int mode  = 0;
  logic [31:0] pd_hist [0:2047];

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .LATENCY(LAT)
  ) dut_p (
    .pixel_clk_i(clk), .reset_i(rst), .hsync_o(hs_p), .vsync_o(vs_p),
    .pixel_data_i(pd), .disp_hsync_o(dhs_p), .disp_vsync_o(dvs_p),
    .disp_de_o(de_p), .disp_rgb_o(rgb_p), .frame_start_o(fs_p)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .LATENCY(LAT)
  ) dut_n (
    .pixel_clk_i(clk), .reset_i(rst), .hsync_o(hs_n), .vsync_o(vs_n),
    .pixel_data_i(pd), .disp_hsync_o(dhs_n), .disp_vsync_o(dvs_n),
    .disp_de_o(de_n), .disp_rgb_o(rgb_n), .frame_start_o(fs_n)
  );

  // Reference model: raster position p counts pixel clocks since the fresh frame began.
  function automatic bit m_hs(int p);
    if (p < 0) return 1'b0;
    return (p % HT) >= HA + HF && (p % HT) < HA + HF + HS;
  endfunction

  function automatic bit m_vs(int p);
    int v;
    if (p < 0) return 1'b0;
    v = (p / HT) % VT;
    return v >= VA + VF && v < VA + VF + VS;
  endfunction

  function automatic bit m_de(int p);
    if (p < 0) return 1'b0;
    return (p % HT) < HA && ((p / HT) % VT) < VA;
  endfunction

  function automatic bit m_fs(int p);
    if (p < 0) return 1'b0;
    return (p % FT) == 0;
  endfunction

  // Renderer stand-in: mode 0 echoes position {h,v,00,AA} LAT cycles after raw sync, 1 random, 2 all ones.
  task automatic drive_pd();
    int p;
    p = cyc - 1 - LAT;
    case (mode)
      0:       pd_hist[cyc] = (p >= 0) ? {8'(p % HT), 8'((p / HT) % VT), 8'h00, 8'hAA} : 32'h0;
      1:       pd_hist[cyc] = $urandom;
      default: pd_hist[cyc] = 32'hFFFF_FFFF;
    endcase
    pd = pd_hist[cyc];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive_pd();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({hs_p, vs_p, dhs_p, dvs_p, de_p, fs_p, rgb_p} !== 30'h0) begin
      n_bad++;
      $display("FAIL reset_pos: got %h expected %h", {hs_p, vs_p, dhs_p, dvs_p, de_p, fs_p, rgb_p}, 30'h0);
    end
    n_cmp++;
    if ({hs_n, vs_n, dhs_n, dvs_n, de_n, fs_n, rgb_n} !== {4'b1111, 2'b00, 24'h0}) begin
      n_bad++;
      $display("FAIL reset_neg: got %h expected %h", {hs_n, vs_n, dhs_n, dvs_n, de_n, fs_n, rgb_n}, {4'b1111, 2'b00, 24'h0});
    end
    rst  = 1'b0;
    cyc  = 0;
    mode = 0;
    drive_pd();
  endtask

  task automatic test_hsync_frame_start();
    int fs_count = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      n_cmp++;
      if (hs_p !== m_hs(cyc - 1) || hs_n !== !m_hs(cyc - 1)) begin
        n_bad++;
        $display("FAIL hsync cyc=%0d: got p=%b n=%b expected active=%b", cyc, hs_p, hs_n, m_hs(cyc - 1));
      end
      n_cmp++;
      if (fs_p !== m_fs(cyc - 1) || fs_n !== m_fs(cyc - 1)) begin
        n_bad++;
        $display("FAIL frame_start cyc=%0d: got p=%b n=%b expected %b", cyc, fs_p, fs_n, m_fs(cyc - 1));
      end
      if (fs_p === 1'b1) fs_count++;
    end
    n_cmp++;
    if (fs_count != 2) begin
      n_bad++;
      $display("FAIL frame_start_count: got %0d expected 2", fs_count);
    end
  endtask

  task automatic test_vsync();
    for (int i = 0; i < 100; i++) begin
      step();
      n_cmp++;
      if (vs_p !== m_vs(cyc - 1) || vs_n !== !m_vs(cyc - 1)) begin
        n_bad++;
        $display("FAIL vsync cyc=%0d: got p=%b n=%b expected active=%b", cyc, vs_p, vs_n, m_vs(cyc - 1));
      end
    end
  endtask

  // Display side seen LAT+1 cycles after the raw side, checked for both polarities.
  task automatic test_display(input int m, input int cycles);
    int q;
    logic [23:0] e_rgb;
    mode = m;
    for (int i = 0; i < cycles; i++) begin
      step();
      q     = cyc - LAT - 2;
      e_rgb = m_de(q) ? pd_hist[cyc - 1][31:8] : 24'h0;
      n_cmp++;
      if ({dhs_p, dvs_p, de_p} !== {m_hs(q), m_vs(q), m_de(q)}) begin
        n_bad++;
        $display("FAIL disp_sync_pos cyc=%0d: got %b expected %b", cyc, {dhs_p, dvs_p, de_p}, {m_hs(q), m_vs(q), m_de(q)});
      end
      n_cmp++;
      if ({dhs_n, dvs_n, de_n} !== {!m_hs(q), !m_vs(q), m_de(q)}) begin
        n_bad++;
        $display("FAIL disp_sync_neg cyc=%0d: got %b expected %b", cyc, {dhs_n, dvs_n, de_n}, {!m_hs(q), !m_vs(q), m_de(q)});
      end
      n_cmp++;
      if (rgb_p !== e_rgb || rgb_n !== e_rgb) begin
        n_bad++;
        $display("FAIL disp_rgb cyc=%0d: got p=%h n=%h expected %h", cyc, rgb_p, rgb_n, e_rgb);
      end
      if (m == 0 && m_de(q)) begin
        n_cmp++;
        if (rgb_p[23:16] !== 8'(q % HT)) begin
          n_bad++;
          $display("FAIL rgb_h_seq cyc=%0d: got %0d expected %0d", cyc, rgb_p[23:16], q % HT);
        end
      end
      if (m == 2 && !m_de(q)) begin
        n_cmp++;
        if (rgb_p !== 24'h0) begin
          n_bad++;
          $display("FAIL blank_rgb cyc=%0d: got %h expected 000000", cyc, rgb_p);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int guard = 0;
    int q;
    mode = 1;
    while ((cyc % FT) != 2 * HT + 5 && guard < 2 * FT) begin
      step();
      guard++;
    end
    n_cmp++;
    if (guard >= 2 * FT) begin
      n_bad++;
      $display("FAIL midframe_reach: got guard=%0d expected < %0d", guard, 2 * FT);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({hs_p, vs_p, dhs_p, dvs_p, de_p, fs_p, rgb_p} !== 30'h0) begin
      n_bad++;
      $display("FAIL async_reset_pos: got %h expected %h", {hs_p, vs_p, dhs_p, dvs_p, de_p, fs_p, rgb_p}, 30'h0);
    end
    n_cmp++;
    if ({hs_n, vs_n, dhs_n, dvs_n, de_n, fs_n, rgb_n} !== {4'b1111, 2'b00, 24'h0}) begin
      n_bad++;
      $display("FAIL async_reset_neg: got %h expected %h", {hs_n, vs_n, dhs_n, dvs_n, de_n, fs_n, rgb_n}, {4'b1111, 2'b00, 24'h0});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({hs_p, vs_p, dhs_p, dvs_p, de_p, fs_p, rgb_p, hs_n, de_n} !== {30'h0, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d: got %h expected %h", i, {hs_p, vs_p, dhs_p, dvs_p, de_p, fs_p, rgb_p, hs_n, de_n}, {30'h0, 1'b1, 1'b0});
      end
    end
    rst = 1'b0;
    cyc = 0;
    drive_pd();
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      q = cyc - LAT - 2;
      n_cmp++;
      if ({hs_p, vs_p, fs_p} !== {m_hs(cyc - 1), m_vs(cyc - 1), m_fs(cyc - 1)}) begin
        n_bad++;
        $display("FAIL restart_raw cyc=%0d: got %b expected %b", cyc, {hs_p, vs_p, fs_p}, {m_hs(cyc - 1), m_vs(cyc - 1), m_fs(cyc - 1)});
      end
      n_cmp++;
      if ({dhs_n, dvs_n, de_n, rgb_n} !== {!m_hs(q), !m_vs(q), m_de(q), (m_de(q) ? pd_hist[cyc - 1][31:8] : 24'h0)}) begin
        n_bad++;
        $display("FAIL restart_disp cyc=%0d: got %h expected %h", cyc, {dhs_n, dvs_n, de_n, rgb_n},
                 {!m_hs(q), !m_vs(q), m_de(q), (m_de(q) ? pd_hist[cyc - 1][31:8] : 24'h0)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_hsync_frame_start();
    test_vsync();
    test_display(0, 2 * FT);
    test_display(1, 2 * FT);
    test_display(2, FT);
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
